// File: rtl/instr_fetch.sv
// MIPS instruction-fetch stage. It issues word fetches with at most one request outstanding, buffers one word when downstream stalls, and flushes on redirect.
// Optional build macro FETCH_PERF_EN adds saturating fetch and stall performance counters.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        valid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        valid_q, valid_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] discard_addr_q, discard_addr_d;
  logic        consumed;

  assign consumed = valid_q && !stall;

  // NOTE: state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      pc_q           <= RESET_PC;
      instr_q        <= '0;
      pc_out_q       <= RESET_PC;
      valid_q        <= 1'b0;
      // NOTE: the skid payload is reset too, so a flush can never expose a stale word.
      skid_instr_q   <= '0;
      skid_pc_q      <= '0;
      discard_addr_q <= '0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      instr_q        <= instr_d;
      pc_out_q       <= pc_out_d;
      valid_q        <= valid_d;
      skid_instr_q   <= skid_instr_d;
      skid_pc_q      <= skid_pc_d;
      discard_addr_q <= discard_addr_d;
    end
  end

  always_comb begin
    // NOTE: every next-state value gets a hold default first, so no path can infer a latch.
    state_d        = state_q;
    pc_d           = pc_q;
    instr_d        = instr_q;
    pc_out_d       = pc_out_q;
    valid_d        = consumed ? 1'b0 : valid_q;
    skid_instr_d   = skid_instr_q;
    skid_pc_d      = skid_pc_q;
    discard_addr_d = discard_addr_q;

    if (redirect) begin
      pc_d         = redirect_pc & 32'hFFFF_FFFC;
      valid_d      = 1'b0;
      instr_d      = '0;
      skid_instr_d = '0;
      skid_pc_d    = '0;
      unique case (state_q)
        FETCH: begin
          // Without a response in hand, keep asking at the old address until it is answered.
          state_d        = imem_rvalid ? FETCH : DISCARD;
          discard_addr_d = pc_q;
        end
        DISCARD: state_d = imem_rvalid ? FETCH : DISCARD;
        default: state_d = FETCH;
      endcase
    end else begin
      unique case (state_q)
        IDLE: state_d = FETCH;
        FETCH: begin
          if (imem_rvalid) begin
            pc_d = pc_q + 32'd4;
            if (!valid_q || !stall) begin
              instr_d  = imem_rdata;
              pc_out_d = pc_q;
              valid_d  = 1'b1;
            end else begin
              skid_instr_d = imem_rdata;
              skid_pc_d    = pc_q;
              state_d      = HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            instr_d  = skid_instr_q;
            pc_out_d = skid_pc_q;
            valid_d  = 1'b1;
            state_d  = FETCH;
          end
        end
        DISCARD: begin
          if (imem_rvalid) state_d = FETCH;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign imem_req    = (state_q == FETCH) || (state_q == DISCARD);
  assign imem_addr   = (state_q == DISCARD) ? discard_addr_q : pc_q;
  assign instruction = instr_q;
  assign pc_out      = pc_out_q;
  assign pc_plus4    = pc_out_q + 32'd4;
  assign valid       = valid_q;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (consumed && (fetch_cnt_q != 32'hFFFF_FFFF)) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (valid_q && stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: directed cycle table, mid-HOLD reset, reset-PC wrap, then random traffic against a stream-level model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_rvalid, stall, redirect, valid;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, instruction, pc_out, pc_plus4;

  logic        req2, rvalid2, valid2;
  logic [31:0] addr2, rdata2, instr2, pc_out2, pc_plus4_2;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt, perf_fetch2, perf_stall2;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .instruction(instruction), .pc_out(pc_out), .pc_plus4(pc_plus4), .valid(valid)
`ifdef FETCH_PERF_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req(req2), .imem_addr(addr2),
    .imem_rvalid(rvalid2), .imem_rdata(rdata2),
    .stall(1'b0), .redirect(1'b0), .redirect_pc(32'h0),
    .instruction(instr2), .pc_out(pc_out2), .pc_plus4(pc_plus4_2), .valid(valid2)
`ifdef FETCH_PERF_EN
    , .perf_fetch_cnt(perf_fetch2), .perf_stall_cnt(perf_stall2)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory image: odd multiplier keeps every address's word distinct.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h0001_0001) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rv, input logic [31:0] rd, input logic st,
                       input logic rdr, input logic [31:0] rpc);
    imem_rvalid = rv;
    imem_rdata  = rd;
    stall       = st;
    redirect    = rdr;
    redirect_pc = rpc;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    rvalid2 = 1'b0;
    rdata2  = '0;
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        rv;
    logic [31:0] rd;
    logic        st;
    logic        rdr;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
  } vec_t;

  function automatic vec_t mk(input logic rv, input logic [31:0] rd, input logic st,
                              input logic rdr, input logic [31:0] rpc, input logic e_req,
                              input logic [31:0] e_addr, input logic e_valid,
                              input logic [31:0] e_instr, input logic [31:0] e_pc);
    vec_t v;
    v.rv = rv; v.rd = rd; v.st = st; v.rdr = rdr; v.rpc = rpc;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_instr = e_instr; v.e_pc = e_pc;
    return v;
  endfunction

  vec_t vt[19];

  // Random-phase model state
  logic [31:0] exp_pc, mem_addr, prev_instr, prev_pc, rpc;
  logic        outstanding, prev_req, prev_valid, prev_stall, prev_redir, rv, st, rdr;
  int          lat_cnt, n_consumed;
  int          exp_fetch, exp_stall;

  initial begin
    // Rows: inputs for this cycle, then outputs expected during this cycle.
    vt[0]  = mk(0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0);
    vt[1]  = mk(0, 32'h0,         0, 0, 32'h0,         1, 32'h0,         0, 32'h0,         32'h0);
    vt[2]  = mk(1, 32'h3401_3000, 0, 0, 32'h0,         1, 32'h0,         0, 32'h0,         32'h0);
    vt[3]  = mk(1, 32'h3801_0000, 0, 0, 32'h0,         1, 32'h4,         1, 32'h3401_3000, 32'h0);
    vt[4]  = mk(0, 32'h0,         1, 0, 32'h0,         1, 32'h8,         1, 32'h3801_0000, 32'h4);
    vt[5]  = mk(1, 32'h2002_0008, 1, 0, 32'h0,         1, 32'h8,         1, 32'h3801_0000, 32'h4);
    vt[6]  = mk(0, 32'h0,         1, 0, 32'h0,         0, 32'h0,         1, 32'h3801_0000, 32'h4);
    vt[7]  = mk(0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         1, 32'h3801_0000, 32'h4);
    vt[8]  = mk(0, 32'h0,         0, 0, 32'h0,         1, 32'hC,         1, 32'h2002_0008, 32'h8);
    vt[9]  = mk(0, 32'h0,         0, 1, 32'h0000_0103, 1, 32'hC,         0, 32'h2002_0008, 32'h8);
    vt[10] = mk(1, 32'hDEAD_BEEF, 0, 0, 32'h0,         1, 32'hC,         0, 32'h0,         32'h8);
    vt[11] = mk(1, 32'h2403_0100, 0, 0, 32'h0,         1, 32'h100,       0, 32'h0,         32'h8);
    vt[12] = mk(1, 32'h5555_5555, 1, 1, 32'hFFFF_FFFF, 1, 32'h104,       1, 32'h2403_0100, 32'h100);
    vt[13] = mk(1, 32'h1111_2222, 0, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 32'h0,         32'h100);
    vt[14] = mk(0, 32'h0,         0, 0, 32'h0,         1, 32'h0,         1, 32'h1111_2222, 32'hFFFF_FFFC);
    vt[15] = mk(1, 32'hAAAA_0000, 0, 0, 32'h0,         1, 32'h0,         0, 32'h1111_2222, 32'hFFFF_FFFC);
    vt[16] = mk(1, 32'hBBBB_0004, 1, 0, 32'h0,         1, 32'h4,         1, 32'hAAAA_0000, 32'h0);
    vt[17] = mk(0, 32'h0,         1, 1, 32'h0000_0040, 0, 32'h0,         1, 32'hAAAA_0000, 32'h0);
    vt[18] = mk(0, 32'h0,         0, 0, 32'h0,         1, 32'h40,        0, 32'h0,         32'h0);

    do_reset();
    check("rst_pc_plus4", pc_plus4, 32'h4);
`ifdef FETCH_PERF_EN
    check("rst_perf_fetch", perf_fetch_cnt, 32'h0);
    check("rst_perf_stall", perf_stall_cnt, 32'h0);
`endif

    for (int i = 0; i < 19; i++) begin
      check($sformatf("v%0d_req", i), {31'b0, imem_req}, {31'b0, vt[i].e_req});
      if (vt[i].e_req) check($sformatf("v%0d_addr", i), imem_addr, vt[i].e_addr);
      check($sformatf("v%0d_valid", i), {31'b0, valid}, {31'b0, vt[i].e_valid});
      check($sformatf("v%0d_instr", i), instruction, vt[i].e_instr);
      check($sformatf("v%0d_pc_out", i), pc_out, vt[i].e_pc);
      check($sformatf("v%0d_pc_plus4", i), pc_plus4, vt[i].e_pc + 32'd4);
      drive(vt[i].rv, vt[i].rd, vt[i].st, vt[i].rdr, vt[i].rpc);
      next_cycle();
    end

    // Reset while a word sits in the skid buffer.
    drive(1, 32'h0123_4567, 0, 0, 0);
    next_cycle();
    drive(1, 32'h0BAD_0044, 1, 0, 0);
    next_cycle();
    check("hold_req", {31'b0, imem_req}, 32'h0);
    check("hold_valid", {31'b0, valid}, 32'h1);
    check("hold_instr", instruction, 32'h0123_4567);
    rst_n = 1'b0;
    drive(0, 0, 1, 0, 0);
    next_cycle();
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0);
    check("mrst_valid", {31'b0, valid}, 32'h0);
    check("mrst_instr", instruction, 32'h0);
    check("mrst_pc_out", pc_out, 32'h0);
    check("mrst_req", {31'b0, imem_req}, 32'h0);
    check("wrap_rst_pc_out", pc_out2, 32'hFFFF_FFFC);
    check("wrap_rst_pc_plus4", pc_plus4_2, 32'h0);
    check("wrap_rst_req", {31'b0, req2}, 32'h0);
`ifdef FETCH_PERF_EN
    check("mrst_perf_fetch", perf_fetch_cnt, 32'h0);
    check("mrst_perf_stall", perf_stall_cnt, 32'h0);
`endif
    next_cycle();
    check("mrst_fetch_addr", imem_addr, 32'h0);
    check("mrst_fetch_req", {31'b0, imem_req}, 32'h1);
    check("wrap_fetch_addr", addr2, 32'hFFFF_FFFC);
    next_cycle();
    drive(1, 32'h7777_0000, 0, 0, 0);
    rvalid2 = 1'b1;
    rdata2  = 32'hC0DE_FFFC;
    next_cycle();
    drive(0, 0, 0, 0, 0);
    rvalid2 = 1'b0;
    check("mrst_first_instr", instruction, 32'h7777_0000);
    check("mrst_first_pc", pc_out, 32'h0);
    check("mrst_first_valid", {31'b0, valid}, 32'h1);
    check("wrap_first_pc", pc_out2, 32'hFFFF_FFFC);
    check("wrap_first_instr", instr2, 32'hC0DE_FFFC);
    check("wrap_next_addr", addr2, 32'h0);

    // Random traffic: every consumed word must be the next in-order word from memory.
    do_reset();
    exp_pc      = 32'h0;
    outstanding = 1'b0;
    prev_req    = 1'b0;
    prev_valid  = 1'b0;
    prev_stall  = 1'b0;
    prev_redir  = 1'b0;
    prev_instr  = '0;
    prev_pc     = '0;
    mem_addr    = '0;
    lat_cnt     = 0;
    n_consumed  = 0;
    exp_fetch   = 0;
    exp_stall   = 0;
    for (int c = 0; c < 3000; c++) begin
      rv = 1'b0;
      if (outstanding) begin
        check("rnd_req_held", {31'b0, imem_req}, 32'h1);
        check("rnd_addr_stable", imem_addr, mem_addr);
        lat_cnt--;
        if (lat_cnt == 0) begin
          rv = 1'b1;
          outstanding = 1'b0;
        end
      end else if (imem_req) begin
        mem_addr = imem_addr;
        lat_cnt  = prev_req ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 3));
        if (lat_cnt == 0) rv = 1'b1;
        else outstanding = 1'b1;
      end
      st  = ($urandom_range(0, 3) == 0);
      rdr = ($urandom_range(0, 31) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                         : 32'($urandom_range(0, 32'h0000_FFFF));

      if (prev_redir) begin
        check("rnd_redir_valid", {31'b0, valid}, 32'h0);
        check("rnd_redir_nop", instruction, 32'h0);
      end else if (prev_valid && prev_stall) begin
        check("rnd_stall_valid", {31'b0, valid}, 32'h1);
        check("rnd_stall_instr", instruction, prev_instr);
        check("rnd_stall_pc", pc_out, prev_pc);
      end

      if (valid && !st) begin
        check("rnd_pc_order", pc_out, exp_pc);
        check("rnd_instr", instruction, mem_f(pc_out));
        check("rnd_pc_plus4", pc_plus4, pc_out + 32'd4);
        exp_pc = exp_pc + 32'd4;
        n_consumed++;
        exp_fetch++;
      end
      if (valid && st) exp_stall++;
      if (rdr) exp_pc = rpc & 32'hFFFF_FFFC;

      drive(rv, rv ? mem_f(mem_addr) : $urandom, st, rdr, rpc);
      prev_req   = imem_req;
      prev_valid = valid;
      prev_stall = st;
      prev_redir = rdr;
      prev_instr = instruction;
      prev_pc    = pc_out;
      next_cycle();
    end
    check("rnd_progress", {31'b0, n_consumed > 200}, 32'h1);
`ifdef FETCH_PERF_EN
    check("rnd_perf_fetch", perf_fetch_cnt, 32'(exp_fetch));
    check("rnd_perf_stall", perf_stall_cnt, 32'(exp_stall));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
